wta_spike_ctrl: RTL and testbench

WTA_SPIKE_CTRL -- requirements
Module: wta_spike_ctrl

---
 rtl/wta_spike_ctrl.sv | 150 +++++++++++++++
 tb/tb_wta_spike_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wta_spike_ctrl.sv
// Winner-take-all spike controller: fires the comparator's winning neuron once its
// potential crosses threshold, then holds off for a refractory period. SPIKE_COUNT_EN adds per-neuron spike counters.
module wta_spike_ctrl #(
  parameter int p_width     = 19,
  parameter int p_refr      = 16,
  parameter int p_cnt_width = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic [p_width-1:0]     i_result,
  input  logic [7:0]             i_index,
  input  logic [p_width-1:0]     i_threshold,
  output logic [7:0]             o_spike,
  output logic                   o_mem_clr,
  output logic                   o_valid,
  output logic [2:0]             o_winner,
  output logic                   o_busy
`ifdef SPIKE_COUNT_EN
  ,
  input  logic [2:0]             i_cnt_sel,
  input  logic                   i_cnt_clr,
  output logic [p_cnt_width-1:0] o_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_REFRACT
  } state_e;

  localparam int REFR_W = (p_refr > 1) ? $clog2(p_refr) : 1;
  localparam logic [REFR_W-1:0] REFR_LOAD = (p_refr > 0) ? REFR_W'(p_refr - 1) : '0;

  function automatic logic [2:0] encode(input logic [7:0] onehot);
    logic [2:0] code;
    code = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) code = 3'(i);
    end
    return code;
  endfunction

  state_e             state_q, state_d;
  logic [p_width-1:0] r_result_q, r_result_d;
  logic [7:0]         index_q, index_d;
  logic [REFR_W-1:0]  refr_q, refr_d;
  logic [7:0]         spike_q, spike_d;
  logic               mem_clr_q, mem_clr_d;
  logic               valid_q, valid_d;
  logic [2:0]         winner_q, winner_d;
  logic               busy_q, busy_d;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    r_result_d = i_result;
    state_d    = state_q;
    index_d    = index_q;
    refr_d     = refr_q;
    winner_d   = winner_q;
    case (state_q)
      S_IDLE: begin
        if (i_en && $onehot(i_index) && (r_result_q >= i_threshold)) begin
          state_d  = S_FIRE;
          index_d  = i_index;
          winner_d = encode(i_index);
        end
      end
      S_FIRE: begin
        if (p_refr == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REFRACT;
          refr_d  = REFR_LOAD;
        end
      end
      S_REFRACT: begin
        if (refr_q == '0) state_d = S_IDLE;
        else              refr_d  = refr_q - REFR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered: decode them from the state being entered.
    spike_d   = (state_d == S_FIRE) ? index_d : '0;
    mem_clr_d = (state_d == S_FIRE);
    valid_d   = (state_d == S_FIRE);
    busy_d    = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      r_result_q <= '0;
      index_q    <= '0;
      refr_q     <= '0;
      spike_q    <= '0;
      mem_clr_q  <= 1'b0;
      valid_q    <= 1'b0;
      winner_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_result_q <= r_result_d;
      index_q    <= index_d;
      refr_q     <= refr_d;
      spike_q    <= spike_d;
      mem_clr_q  <= mem_clr_d;
      valid_q    <= valid_d;
      winner_q   <= winner_d;
      busy_q     <= busy_d;
    end
  end

  assign o_spike   = spike_q;
  assign o_mem_clr = mem_clr_q;
  assign o_valid   = valid_q;
  assign o_winner  = winner_q;
  assign o_busy    = busy_q;

`ifdef SPIKE_COUNT_EN
  logic [p_cnt_width-1:0] cnt_q [8];
  logic [p_cnt_width-1:0] cnt_d [8];

  // winner_q already holds the firing neuron during FIRE; clear beats increment.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i_cnt_clr) begin
        cnt_d[i] = '0;
      end else if ((state_q == S_FIRE) && (winner_q == 3'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + p_cnt_width'(1);
      end
    end
  end

  // NOTE: the counter array is small register storage, not RAM, so it takes the async reset like any flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign o_cnt = cnt_q[i_cnt_sel];
`endif

endmodule

// File: tb/tb_wta_spike_ctrl.sv
// Directed bench for wta_spike_ctrl: one instance with a 4-cycle refractory period and
// one with none, sharing stimulus. Counter checks run only when SPIKE_COUNT_EN is defined.
module tb_wta_spike_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [18:0] result;
  logic [18:0] thr;
  logic [7:0]  index;

  logic [7:0]  spike, spike0;
  logic        mem_clr, mem_clr0;
  logic        valid, valid0;
  logic [2:0]  winner, winner0;
  logic        busy, busy0;

  int checks   = 0;
  int failures = 0;

`ifdef SPIKE_COUNT_EN
  logic [2:0]  cnt_sel;
  logic        cnt_clr;
  logic [1:0]  cnt;
  logic [7:0]  cnt0;
`endif

  always #5 clk = ~clk;

  wta_spike_ctrl #(.p_width(19), .p_refr(4), .p_cnt_width(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_result(result), .i_index(index),
    .i_threshold(thr), .o_spike(spike), .o_mem_clr(mem_clr), .o_valid(valid),
    .o_winner(winner), .o_busy(busy)
`ifdef SPIKE_COUNT_EN
    , .i_cnt_sel(cnt_sel), .i_cnt_clr(cnt_clr), .o_cnt(cnt)
`endif
  );

  wta_spike_ctrl #(.p_width(19), .p_refr(0), .p_cnt_width(8)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_result(result), .i_index(index),
    .i_threshold(thr), .o_spike(spike0), .o_mem_clr(mem_clr0), .o_valid(valid0),
    .o_winner(winner0), .o_busy(busy0)
`ifdef SPIKE_COUNT_EN
    , .i_cnt_sel(cnt_sel), .i_cnt_clr(cnt_clr), .o_cnt(cnt0)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a comparator evaluation; on return the DUT is in FIRE if it fired.
  task automatic apply(input logic [18:0] r, input logic [7:0] idx);
    result = r;
    index  = 8'h00;
    step();
    index  = idx;
    result = '0;
    step();
    index  = 8'h00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, n);
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; result = '0; index = 8'h00; thr = 19'd100;
`ifdef SPIKE_COUNT_EN
    cnt_sel = 3'd0; cnt_clr = 1'b0;
`endif
    step(); step();
    checks += 5;
    if (spike !== 8'h00) begin failures++; $display("FAIL reset_spike: got %h required 00", spike); end
    if (mem_clr !== 1'b0) begin failures++; $display("FAIL reset_mem_clr: got %b required 0", mem_clr); end
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", valid); end
    if (winner !== 3'd0) begin failures++; $display("FAIL reset_winner: got %0d required 0", winner); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_threshold();
    en = 1'b1; thr = 19'd100;
    result = 19'd150; index = 8'h00;
    step();
    checks++;
    if (spike !== 8'h00) begin failures++; $display("FAIL thr_early: spike %h required 00", spike); end
    index = 8'h04; result = '0;
    step();
    index = 8'h00;
    checks += 5;
    if (spike !== 8'h04) begin failures++; $display("FAIL thr_spike: got %h required 04", spike); end
    if (mem_clr !== 1'b1) begin failures++; $display("FAIL thr_mem_clr: got %b required 1", mem_clr); end
    if (valid !== 1'b1) begin failures++; $display("FAIL thr_valid: got %b required 1", valid); end
    if (winner !== 3'd2) begin failures++; $display("FAIL thr_winner: got %0d required 2", winner); end
    if (busy !== 1'b1) begin failures++; $display("FAIL thr_busy: got %b required 1", busy); end
    step();
    checks += 4;
    if (spike !== 8'h00) begin failures++; $display("FAIL refr_spike: got %h required 00", spike); end
    if (valid !== 1'b0) begin failures++; $display("FAIL refr_valid: got %b required 0", valid); end
    if (winner !== 3'd2) begin failures++; $display("FAIL refr_winner_hold: got %0d required 2", winner); end
    if (busy !== 1'b1) begin failures++; $display("FAIL refr_busy: got %b required 1", busy); end
    wait_idle();
  endtask

  task automatic test_sub_threshold();
    apply(19'd99, 8'h04);
    checks += 2;
    if (spike !== 8'h00) begin failures++; $display("FAIL below_thr_spike: got %h required 00", spike); end
    if (busy !== 1'b0) begin failures++; $display("FAIL below_thr_busy: got %b required 0", busy); end
    apply(19'd100, 8'h80);
    checks += 2;
    if (spike !== 8'h80) begin failures++; $display("FAIL equal_thr_spike: got %h required 80", spike); end
    if (winner !== 3'd7) begin failures++; $display("FAIL equal_thr_winner: got %0d required 7", winner); end
    wait_idle();
  endtask

  task automatic test_invalid_index();
    apply(19'd150, 8'h00);
    checks += 2;
    if (spike !== 8'h00) begin failures++; $display("FAIL zero_idx_spike: got %h required 00", spike); end
    if (busy !== 1'b0) begin failures++; $display("FAIL zero_idx_busy: got %b required 0", busy); end
    apply(19'd150, 8'h11);
    checks += 3;
    if (spike !== 8'h00) begin failures++; $display("FAIL multi_idx_spike: got %h required 00", spike); end
    if (busy !== 1'b0) begin failures++; $display("FAIL multi_idx_busy: got %b required 0", busy); end
    if (winner !== 3'd7) begin failures++; $display("FAIL multi_idx_winner_hold: got %0d required 7", winner); end
  endtask

  task automatic test_refractory();
    int n4 = 0, n0 = 0, last4 = -1, last0 = -1, run4 = 0, run0 = 0;
    result = 19'd150; index = 8'h02;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (spike != 8'h00) begin
        checks += 2;
        if (n4 == 0 && k != 2) begin failures++; $display("FAIL refr4_first: spike at cycle %0d required 2", k); end
        if (n4 > 0 && k - last4 != 6) begin failures++; $display("FAIL refr4_interval: got %0d required 6", k - last4); end
        if (spike !== 8'h02 || mem_clr !== 1'b1 || valid !== 1'b1) begin
          failures++;
          $display("FAIL refr4_fire: spike %h mem_clr %b valid %b required 02 1 1", spike, mem_clr, valid);
        end
        last4 = k; n4++;
      end
      if (spike0 != 8'h00) begin
        checks++;
        if (n0 > 0 && k - last0 != 2) begin failures++; $display("FAIL refr0_interval: got %0d required 2", k - last0); end
        last0 = k; n0++;
      end
      if (busy) run4++;
      else if (run4 != 0) begin
        checks++;
        if (run4 != 5) begin failures++; $display("FAIL refr4_busy_len: got %0d required 5", run4); end
        run4 = 0;
      end
      if (busy0) run0++;
      else if (run0 != 0) begin
        checks++;
        if (run0 != 1) begin failures++; $display("FAIL refr0_busy_len: got %0d required 1", run0); end
        run0 = 0;
      end
    end
    checks += 2;
    if (n4 != 5) begin failures++; $display("FAIL refr4_count: got %0d required 5", n4); end
    if (n0 != 15) begin failures++; $display("FAIL refr0_count: got %0d required 15", n0); end
    result = '0; index = 8'h00;
    wait_idle();
  endtask

  task automatic test_discard();
    int seen = 0;
    apply(19'd150, 8'h04);
    result = 19'd150;
    step();
    index = 8'h04; result = '0;
    step();
    index = 8'h00;
    for (int k = 0; k < 12; k++) begin
      step();
      if (spike != 8'h00) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL discard: got %0d spikes required 0", seen); end
    wait_idle();
  endtask

  task automatic test_reset_mid_refract();
    apply(19'd150, 8'h08);
    checks++;
    if (winner !== 3'd3) begin failures++; $display("FAIL pre_reset_winner: got %0d required 3", winner); end
    step(); step();
    index = 8'h08;
    #1 rst_n = 1'b0;
    #1;
    checks += 5;
    if (spike !== 8'h00) begin failures++; $display("FAIL abort_spike: got %h required 00", spike); end
    if (mem_clr !== 1'b0) begin failures++; $display("FAIL abort_mem_clr: got %b required 0", mem_clr); end
    if (valid !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b required 0", valid); end
    if (winner !== 3'd0) begin failures++; $display("FAIL abort_winner: got %0d required 0", winner); end
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b required 0", busy); end
    #1 rst_n = 1'b1;
    step();
    checks++;
    if (spike !== 8'h00) begin failures++; $display("FAIL post_reset_stale: got %h required 00", spike); end
    index = 8'h00;
    apply(19'd120, 8'h20);
    checks += 3;
    if (spike !== 8'h20) begin failures++; $display("FAIL post_reset_spike: got %h required 20", spike); end
    if (winner !== 3'd5) begin failures++; $display("FAIL post_reset_winner: got %0d required 5", winner); end
    if (valid !== 1'b1) begin failures++; $display("FAIL post_reset_valid: got %b required 1", valid); end
    wait_idle();
  endtask

`ifdef SPIKE_COUNT_EN
  task automatic test_spike_count();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0; cnt_sel = 3'd7;
    apply(19'd150, 8'h80);
    step();
    checks++;
    if (cnt !== 2'd1) begin failures++; $display("FAIL cnt_first: got %0d required 1", cnt); end
    wait_idle();
    for (int s = 0; s < 4; s++) begin
      apply(19'd150, 8'h80);
      wait_idle();
    end
    checks++;
    if (cnt !== 2'd3) begin failures++; $display("FAIL cnt_saturate: got %0d required 3", cnt); end
    apply(19'd150, 8'h80);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (cnt !== 2'd0) begin failures++; $display("FAIL cnt_clr_wins: got %0d required 0", cnt); end
    wait_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_threshold();
    test_sub_threshold();
    test_invalid_index();
    test_refractory();
    test_discard();
    test_reset_mid_refract();
`ifdef SPIKE_COUNT_EN
    test_spike_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
